led_chain_sequencer: RTL and testbench

- Upstream frame sequencer for a chain of NUM_LEDS WS2812B LEDs driven by one led_driver instance.
- Snapshots an on/off bit vector, such as CPU register or bus state, at frame start.
- Presents one 24-bit colour per LED to the driver, in chain order, using the driver's ready/data_latched handshake.
- Waits for the driver to finish, enforces a minimum inter-frame gap, then idles or auto-refreshes.

---
 rtl/led_chain_sequencer.sv | 103 ++++++++++
 tb/tb_led_chain_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chain_sequencer.sv
// Frame sequencer for a WS2812B chain. It snapshots an on/off vector at frame
// start, feeds one GRB word per LED to led_driver, then enforces an idle gap.
module led_chain_sequencer #(
  parameter int          NUM_LEDS     = 16,
  parameter logic [23:0] COLOR_ON     = 24'h00ff00,
  parameter logic [23:0] COLOR_OFF    = 24'h000000,
  parameter int          GAP_CYCLES   = 27_000,
  parameter bit          AUTO_REFRESH = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_LEDS-1:0]         bits,
  output logic                        drv_ready,
  output logic [23:0]                 drv_rgb,
  input  logic                        drv_busy,
  input  logic                        drv_latched,
  output logic [$clog2(NUM_LEDS)-1:0] led_idx,
  output logic                        frame_active,
  output logic                        frame_done
);

  localparam int IW = $clog2(NUM_LEDS);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SNAPSHOT, FEED, DRAIN, GAP} state_t;

  state_t              state_q, state_d;
  logic [NUM_LEDS-1:0] shadow_q, shadow_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                pending_q, pending_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    pending_d = pending_q;
    // Requests while busy collapse into one deferred frame.
    if (start && (state_q != IDLE)) pending_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start || pending_q || AUTO_REFRESH) begin
          state_d   = SNAPSHOT;
          pending_d = 1'b0;
        end
      end
      SNAPSHOT: begin
        shadow_d = bits;
        idx_d    = '0;
        state_d  = FEED;
      end
      FEED: begin
        if (drv_latched) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (!drv_busy) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops them without a clock.
  assign drv_ready    = (state_q == FEED);
  assign frame_active = (state_q == SNAPSHOT) || (state_q == FEED) || (state_q == DRAIN);
  assign frame_done   = (state_q == DRAIN) && !drv_busy;
  assign led_idx      = idx_q;
  assign drv_rgb      = shadow_q[idx_q] ? COLOR_ON : COLOR_OFF;

endmodule

// File: tb/tb_led_chain_sequencer.sv
// Randomized scoreboard bench: a manual-start instance and an auto-refresh
// instance, each fed by a simple led_driver behavioural model.
module tb_led_chain_sequencer;
  localparam int N  = 4;
  localparam int G0 = 20;
  localparam int G1 = 10;
  localparam logic [23:0] ON  = 24'h00ff00;
  localparam logic [23:0] OFF = 24'h000000;

  typedef struct {logic [23:0] rgb; logic [1:0] idx;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Manual-start instance
  logic rst0, start0, rdy0, busy0, lat0, act0, done0;
  logic [3:0] bits0;
  logic [23:0] rgb0;
  logic [1:0] idx0;
  led_chain_sequencer #(.NUM_LEDS(N), .COLOR_ON(ON), .COLOR_OFF(OFF),
                        .GAP_CYCLES(G0), .AUTO_REFRESH(1'b0)) dut (
    .clk(clk), .rst(rst0), .start(start0), .bits(bits0), .drv_ready(rdy0),
    .drv_rgb(rgb0), .drv_busy(busy0), .drv_latched(lat0), .led_idx(idx0),
    .frame_active(act0), .frame_done(done0));

  // Auto-refresh instance
  logic rst_a, start_a, rdy_a, busy_a, lat_a, act_a, done_a;
  logic [3:0] bits_a;
  logic [23:0] rgb_a;
  logic [1:0] idx_a;
  led_chain_sequencer #(.NUM_LEDS(N), .COLOR_ON(ON), .COLOR_OFF(OFF),
                        .GAP_CYCLES(G1), .AUTO_REFRESH(1'b1)) dut_ar (
    .clk(clk), .rst(rst_a), .start(start_a), .bits(bits_a), .drv_ready(rdy_a),
    .drv_rgb(rgb_a), .drv_busy(busy_a), .drv_latched(lat_a), .led_idx(idx_a),
    .frame_active(act_a), .frame_done(done_a));

  // Driver model: latches a word when ready and its shifter has room, and
  // stays busy for a while after the last latch (word + reset period).
  int w0 = 0, b0 = 0, wa = 0, ba = 0;
  initial begin
    lat0 = 1'b0; busy0 = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst0) begin
        lat0 <= 1'b0; busy0 <= 1'b0; w0 = 0; b0 = 0;
      end else begin
        lat0 <= 1'b0;
        if (w0 > 0) w0--;
        if (b0 > 0) b0--;
        if (rdy0 && !lat0 && w0 == 0) begin
          lat0 <= 1'b1;
          w0 = 1 + int'($urandom % 4);
          b0 = 14;
        end
        busy0 <= (b0 != 0);
      end
    end
  end
  initial begin
    lat_a = 1'b0; busy_a = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_a) begin
        lat_a <= 1'b0; busy_a <= 1'b0; wa = 0; ba = 0;
      end else begin
        lat_a <= 1'b0;
        if (wa > 0) wa--;
        if (ba > 0) ba--;
        if (rdy_a && !lat_a && wa == 0) begin
          lat_a <= 1'b1;
          wa = 1 + int'($urandom % 4);
          ba = 14;
        end
        busy_a <= (ba != 0);
      end
    end
  end

  // Scoreboard for the manual instance
  exp_t exp_q[$];
  int lat_cnt0 = 0, starts0 = 0;
  task automatic push_frame(input logic [3:0] v);
    for (int k = 0; k < N; k++) exp_q.push_back('{v[k] ? ON : OFF, 2'(k)});
  endtask

  initial begin
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst0) begin
        lat_cnt0 = 0; prev = 1'b0;
      end else begin
        if (lat0) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_latch: got rgb %0h with no word expected at cycle %0d", rgb0, cyc);
          end else begin
            e = exp_q.pop_front();
            check("latched_rgb", rgb0, e.rgb);
            check("latched_idx", idx0, e.idx);
          end
          lat_cnt0++;
        end
        if (done0) begin
          check("latches_per_frame", lat_cnt0, N);
          check("busy_low_at_done", busy0, 0);
          lat_cnt0 = 0;
        end
        if (act0 && !prev) starts0++;
        prev = act0;
      end
    end
  end

  // Checker for the auto-refresh instance, modelled from frame rules directly
  int lcnt_a = 0, frames_a = 0, prev_done_a = -1, rise_a = 0;
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        if (lat_a) begin
          if (lcnt_a < N) begin
            check("ar_rgb", rgb_a, bits_a[lcnt_a] ? ON : OFF);
            check("ar_idx", idx_a, lcnt_a);
          end else begin
            n_chk++; n_fail++;
            $display("FAIL ar_extra_latch: got latch %0d expected at most %0d", lcnt_a + 1, N);
          end
          lcnt_a++;
        end
        if (act_a && !prev) rise_a = cyc;
        if (done_a) begin
          check("ar_latches", lcnt_a, N);
          if (prev_done_a >= 0)
            check("ar_spacing", (cyc - prev_done_a) >= (cyc - rise_a) + G1 + 2, 1);
          prev_done_a = cyc;
          frames_a++;
          lcnt_a = 0;
        end
        prev = act_a;
      end
    end
  end

  task automatic wait_active0(input int lim);
    int t = 0;
    while (!act0 && t < lim) begin @(negedge clk); t++; end
    check("wait_frame_active", act0, 1);
  endtask
  task automatic wait_done0(input int lim);
    int t = 0;
    while (!done0 && t < lim) begin @(negedge clk); t++; end
    check("wait_frame_done", done0, 1);
  endtask
  task automatic wait_lat0(input int n, input int lim);
    int t = 0;
    while (lat_cnt0 < n && t < lim) begin @(negedge clk); t++; end
    check("wait_latches", lat_cnt0 >= n, 1);
  endtask

  // Bits are scrambled one cycle after SNAPSHOT to prove the frame uses the copy.
  task automatic run_frame(input logic [3:0] v);
    push_frame(v);
    bits0 = v; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_active0(10);
    @(negedge clk); bits0 = ~v;
    wait_done0(200);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] v, w;
    int d, s;
    rst0 = 1'b0; rst_a = 1'b0; start0 = 1'b0; start_a = 1'b0;
    bits0 = 4'hF; bits_a = 4'($urandom);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start0 = i[0];
      check("rst_ready", rdy0, 0);
      check("rst_idx", idx0, 0);
      check("rst_rgb", rgb0, OFF);
      check("rst_done", done0, 0);
      check("rst_active", act0, 0);
    end
    @(negedge clk);
    rst0 = 1'b1; rst_a = 1'b1; start0 = 1'b0; bits0 = 4'h0;

    run_frame(4'b0101);
    repeat (G0 + 3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      run_frame(4'($urandom));
      repeat (G0 + 3) @(negedge clk);
    end

    // Several requests mid-frame yield exactly one follow-on frame after the gap.
    v = 4'($urandom);
    push_frame(v);
    bits0 = v; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_active0(10);
    @(negedge clk);
    w = 4'($urandom);
    bits0 = w;
    push_frame(w);
    s = starts0;
    wait_lat0(1, 50);
    for (int i = 0; i < 3; i++) begin
      start0 = 1'b1; @(negedge clk);
      start0 = 1'b0; @(negedge clk);
    end
    wait_done0(200);
    d = cyc;
    @(negedge clk);
    wait_active0(G0 + 20);
    check("pending_gap", (cyc - d) >= G0 + 2, 1);
    @(negedge clk); bits0 = ~w;
    wait_done0(200);
    repeat (G0 + 40) @(negedge clk);
    check("single_pending_frame", starts0 - s, 1);

    // Reset mid-frame
    v = 4'($urandom);
    push_frame(v);
    bits0 = v; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_lat0(2, 60);
    #2 rst0 = 1'b0;
    #1;
    check("midrst_ready", rdy0, 0);
    check("midrst_idx", idx0, 0);
    check("midrst_active", act0, 0);
    check("midrst_rgb", rgb0, OFF);
    exp_q.delete();
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk);
    run_frame(4'($urandom));
    check("queue_drained", exp_q.size(), 0);

    repeat (G0 + 5) @(negedge clk);
    check("ar_frames", frames_a >= 3, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
